// File: rtl/ex_result_buffer.sv
// Two-entry result skid buffer between EX and MEM with decode operand forwarding.
// Latency: a pushed entry reaches out_* on the next cycle at the earliest; no in->out bypass.
// Backpressure: in_ready depends only on registered occupancy (low when full), never on out_ready.
//
// Ports:
//   clock, resetn                : clock, asynchronous active-low reset
//   in_valid/in_ready, in_*      : EX result, flags and control (push side)
//   flush                        : drop all held entries and any same-cycle push
//   out_valid/out_ready, out_*   : head (oldest) entry toward MEM (pop side)
//   fwd_rs/fwd_rt -> fwd_*       : combinational lookup over held entries, youngest wins
//   occupancy                    : number of held entries (0..2)
module ex_result_buffer #(
    parameter int DEPTH = 2,
    parameter int DW    = 32
) (
    input  logic          clock,
    input  logic          resetn,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_r,
    input  logic          in_z,
    input  logic [4:0]    in_rn,
    input  logic          in_wreg,
    input  logic          in_m2reg,
    input  logic          in_wmem,
    input  logic [DW-1:0] in_sv,
    input  logic          flush,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_r,
    output logic          out_z,
    output logic [4:0]    out_rn,
    output logic          out_wreg,
    output logic          out_m2reg,
    output logic          out_wmem,
    output logic [DW-1:0] out_sv,
    input  logic [4:0]    fwd_rs,
    input  logic [4:0]    fwd_rt,
    output logic          fwd_a_hit,
    output logic [DW-1:0] fwd_a_data,
    output logic          fwd_b_hit,
    output logic [DW-1:0] fwd_b_data,
    output logic          fwd_stall,
    output logic [1:0]    occupancy
);

    typedef struct packed {
        logic [DW-1:0] r;
        logic          z;
        logic [4:0]    rn;
        logic          wreg;
        logic          m2reg;
        logic          wmem;
        logic [DW-1:0] sv;
    } ent_t;

    // ent0 is always the head (oldest); ent1 is only meaningful when two are held.
    ent_t       ent0_q, ent0_d;
    ent_t       ent1_q, ent1_d;
    logic [1:0] occupancy_q, occupancy_d;

    ent_t in_ent;
    logic push;
    logic pop;

    assign in_ent = '{r: in_r, z: in_z, rn: in_rn, wreg: in_wreg,
                      m2reg: in_m2reg, wmem: in_wmem, sv: in_sv};

    assign in_ready  = (occupancy_q != 2'(DEPTH));
    assign out_valid = (occupancy_q != 2'd0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    always_comb begin
        ent0_d      = ent0_q;
        ent1_d      = ent1_q;
        occupancy_d = occupancy_q;
        if (flush) begin
            occupancy_d = 2'd0;
        end else begin
            case (occupancy_q)
                2'd0: begin
                    if (push) begin
                        ent0_d      = in_ent;
                        occupancy_d = 2'd1;
                    end
                end
                2'd1: begin
                    if (push && pop) begin
                        ent0_d = in_ent;         // head leaves, newcomer becomes head
                    end else if (push) begin
                        ent1_d      = in_ent;
                        occupancy_d = 2'd2;
                    end else if (pop) begin
                        occupancy_d = 2'd0;
                    end
                end
                default: begin
                    if (pop) begin
                        ent0_d      = ent1_q;    // promote second entry
                        occupancy_d = 2'd1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            ent0_q      <= '0;
            ent1_q      <= '0;
            occupancy_q <= 2'd0;
        end else begin
            ent0_q      <= ent0_d;
            ent1_q      <= ent1_d;
            occupancy_q <= occupancy_d;
        end
    end

    assign out_r     = ent0_q.r;
    assign out_z     = ent0_q.z;
    assign out_rn    = ent0_q.rn;
    assign out_wreg  = ent0_q.wreg;
    assign out_m2reg = ent0_q.m2reg;
    assign out_wmem  = ent0_q.wmem;
    assign out_sv    = ent0_q.sv;
    assign occupancy = occupancy_q;

    // Returns {load_hit, hit, data}. The younger entry is examined first so it
    // shadows the older one; a load match suppresses the hit and requests a stall.
    function automatic logic [DW+1:0] fwd_lookup(input logic [4:0] src,
                                                 input ent_t e0, input ent_t e1,
                                                 input logic [1:0] occ);
        logic m0;
        logic m1;
        ent_t sel;
        m1  = (occ == 2'd2) && e1.wreg && (e1.rn == src) && (src != 5'd0);
        m0  = (occ != 2'd0) && e0.wreg && (e0.rn == src) && (src != 5'd0);
        sel = m1 ? e1 : e0;
        if (m1 || m0) begin
            if (sel.m2reg) fwd_lookup = {1'b1, 1'b0, {DW{1'b0}}};
            else           fwd_lookup = {1'b0, 1'b1, sel.r};
        end else begin
            fwd_lookup = '0;
        end
    endfunction

    logic [DW+1:0] look_a;
    logic [DW+1:0] look_b;

    assign look_a     = fwd_lookup(fwd_rs, ent0_q, ent1_q, occupancy_q);
    assign look_b     = fwd_lookup(fwd_rt, ent0_q, ent1_q, occupancy_q);
    assign fwd_a_hit  = look_a[DW];
    assign fwd_a_data = look_a[DW-1:0];
    assign fwd_b_hit  = look_b[DW];
    assign fwd_b_data = look_b[DW-1:0];
    assign fwd_stall  = look_a[DW+1] | look_b[DW+1];

endmodule

// File: tb/tb_ex_result_buffer.sv
module tb_ex_result_buffer;

    logic        clock, resetn;
    logic        in_valid, in_ready;
    logic [31:0] in_r, in_sv;
    logic        in_z, in_wreg, in_m2reg, in_wmem;
    logic [4:0]  in_rn;
    logic        flush;
    logic        out_valid, out_ready;
    logic [31:0] out_r, out_sv;
    logic        out_z, out_wreg, out_m2reg, out_wmem;
    logic [4:0]  out_rn;
    logic [4:0]  fwd_rs, fwd_rt;
    logic        fwd_a_hit, fwd_b_hit, fwd_stall;
    logic [31:0] fwd_a_data, fwd_b_data;
    logic [1:0]  occupancy;

    int total = 0;
    int bad   = 0;

    ex_result_buffer dut (
        .clock(clock), .resetn(resetn),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_r(in_r), .in_z(in_z), .in_rn(in_rn), .in_wreg(in_wreg),
        .in_m2reg(in_m2reg), .in_wmem(in_wmem), .in_sv(in_sv),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_r(out_r), .out_z(out_z), .out_rn(out_rn), .out_wreg(out_wreg),
        .out_m2reg(out_m2reg), .out_wmem(out_wmem), .out_sv(out_sv),
        .fwd_rs(fwd_rs), .fwd_rt(fwd_rt),
        .fwd_a_hit(fwd_a_hit), .fwd_a_data(fwd_a_data),
        .fwd_b_hit(fwd_b_hit), .fwd_b_data(fwd_b_data),
        .fwd_stall(fwd_stall), .occupancy(occupancy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] r, input logic [4:0] rn,
                         input logic wreg, input logic m2, input logic ordy,
                         input logic fl, input logic [4:0] rs, input logic [4:0] rt);
        in_valid = v; in_r = r; in_rn = rn; in_wreg = wreg; in_m2reg = m2;
        in_z = 1'b0; in_wmem = 1'b0; in_sv = 32'h0;
        out_ready = ordy; flush = fl; fwd_rs = rs; fwd_rt = rt;
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic v; logic [31:0] r; logic [4:0] rn; logic wreg; logic m2;
        logic ordy; logic fl; logic [4:0] rs; logic [4:0] rt;
        logic e_ovld; logic [31:0] e_or; logic [1:0] e_occ; logic e_irdy;
        logic e_ahit; logic [31:0] e_adata; logic e_bhit; logic e_stall;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic v, logic [31:0] r, logic [4:0] rn, logic wreg,
                                logic m2, logic ordy, logic fl, logic [4:0] rs,
                                logic [4:0] rt, logic eov, logic [31:0] eor,
                                logic [1:0] eocc, logic eirdy, logic eah,
                                logic [31:0] ead, logic ebh, logic est);
        vec_t t;
        t.v = v; t.r = r; t.rn = rn; t.wreg = wreg; t.m2 = m2; t.ordy = ordy;
        t.fl = fl; t.rs = rs; t.rt = rt; t.e_ovld = eov; t.e_or = eor;
        t.e_occ = eocc; t.e_irdy = eirdy; t.e_ahit = eah; t.e_adata = ead;
        t.e_bhit = ebh; t.e_stall = est;
        return t;
    endfunction

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] r; logic z; logic [4:0] rn; logic wreg; logic m2; logic wmem;
        logic [31:0] sv;
    } m_t;

    m_t q[$];

    function automatic void mlook(input logic [4:0] src, output logic hit,
                                  output logic [31:0] d, output logic ld);
        hit = 1'b0; d = 32'h0; ld = 1'b0;
        if (src != 5'd0) begin
            for (int i = q.size() - 1; i >= 0; i--) begin
                if (q[i].wreg && q[i].rn == src) begin
                    if (q[i].m2) ld = 1'b1;
                    else begin hit = 1'b1; d = q[i].r; end
                    break;
                end
            end
        end
    endfunction

    initial begin
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        resetn = 1'b0;

        #2;
        chk("rst_occ", 32'(occupancy), 0);
        chk("rst_ovld", 32'(out_valid), 0);
        chk("rst_irdy", 32'(in_ready), 1);
        chk("rst_out_r", out_r, 0);
        chk("rst_out_sv", out_sv, 0);
        chk("rst_out_rn", 32'(out_rn), 0);
        chk("rst_fwd", {29'h0, fwd_a_hit, fwd_b_hit, fwd_stall}, 0);
        chk("rst_fwd_data", fwd_a_data | fwd_b_data, 0);
        #10 resetn = 1'b1;
        step();

        // plan 1, 2, 4 plus youngest-load shadowing and wreg=0
        vecs.push_back(mk(0, 0,      0, 0, 0, 1, 0, 3, 0,  0, 0,      0, 1, 0, 0,      0, 0));
        vecs.push_back(mk(1, 5,      3, 1, 0, 1, 0, 3, 0,  0, 0,      0, 1, 0, 0,      0, 0));
        vecs.push_back(mk(0, 0,      0, 0, 0, 1, 0, 3, 0,  1, 5,      1, 1, 1, 5,      0, 0));
        vecs.push_back(mk(0, 0,      0, 0, 0, 0, 0, 3, 0,  0, 0,      0, 1, 0, 0,      0, 0));
        vecs.push_back(mk(1, 'h11,   4, 1, 0, 0, 0, 4, 0,  0, 0,      0, 1, 0, 0,      0, 0));
        vecs.push_back(mk(1, 'h22,   4, 1, 0, 0, 0, 4, 0,  1, 'h11,   1, 1, 1, 'h11,   0, 0));
        vecs.push_back(mk(1, 'h33,   4, 1, 0, 0, 0, 4, 0,  1, 'h11,   2, 0, 1, 'h22,   0, 0));
        vecs.push_back(mk(0, 0,      0, 0, 0, 1, 0, 4, 0,  1, 'h11,   2, 0, 1, 'h22,   0, 0));
        vecs.push_back(mk(0, 0,      0, 0, 0, 1, 0, 4, 0,  1, 'h22,   1, 1, 1, 'h22,   0, 0));
        vecs.push_back(mk(0, 0,      0, 0, 0, 0, 0, 4, 0,  0, 0,      0, 1, 0, 0,      0, 0));
        vecs.push_back(mk(1, 'h70,   7, 1, 1, 0, 0, 0, 7,  0, 0,      0, 1, 0, 0,      0, 0));
        vecs.push_back(mk(1, 'h80,   0, 1, 0, 0, 0, 0, 7,  1, 'h70,   1, 1, 0, 0,      0, 1));
        vecs.push_back(mk(0, 0,      0, 0, 0, 0, 0, 0, 7,  1, 'h70,   2, 0, 0, 0,      0, 1));
        vecs.push_back(mk(0, 0,      0, 0, 0, 0, 1, 7, 0,  1, 'h70,   2, 0, 0, 0,      0, 1));
        vecs.push_back(mk(0, 0,      0, 0, 0, 0, 0, 7, 0,  0, 0,      0, 1, 0, 0,      0, 0));
        vecs.push_back(mk(1, 'h99,   9, 1, 0, 0, 0, 9, 9,  0, 0,      0, 1, 0, 0,      0, 0));
        vecs.push_back(mk(1, 'hA0,   9, 1, 1, 0, 0, 9, 9,  1, 'h99,   1, 1, 1, 'h99,   1, 0));
        vecs.push_back(mk(0, 0,      0, 0, 0, 0, 0, 9, 9,  1, 'h99,   2, 0, 0, 0,      0, 1));
        vecs.push_back(mk(0, 0,      0, 0, 0, 0, 1, 9, 9,  1, 'h99,   2, 0, 0, 0,      0, 1));
        vecs.push_back(mk(0, 0,      0, 0, 0, 0, 0, 9, 9,  0, 0,      0, 1, 0, 0,      0, 0));
        vecs.push_back(mk(1, 'h55,   5, 0, 0, 0, 0, 5, 0,  0, 0,      0, 1, 0, 0,      0, 0));
        vecs.push_back(mk(0, 0,      0, 0, 0, 1, 0, 5, 0,  1, 'h55,   1, 1, 0, 0,      0, 0));
        vecs.push_back(mk(0, 0,      0, 0, 0, 0, 0, 5, 0,  0, 0,      0, 1, 0, 0,      0, 0));

        foreach (vecs[i]) begin
            vec_t t;
            t = vecs[i];
            drive(t.v, t.r, t.rn, t.wreg, t.m2, t.ordy, t.fl, t.rs, t.rt);
            #1;
            chk($sformatf("v%0d_ovld", i), 32'(out_valid), 32'(t.e_ovld));
            if (t.e_ovld) chk($sformatf("v%0d_out_r", i), out_r, t.e_or);
            chk($sformatf("v%0d_occ", i), 32'(occupancy), 32'(t.e_occ));
            chk($sformatf("v%0d_irdy", i), 32'(in_ready), 32'(t.e_irdy));
            chk($sformatf("v%0d_ahit", i), 32'(fwd_a_hit), 32'(t.e_ahit));
            chk($sformatf("v%0d_adata", i), fwd_a_data, t.e_adata);
            chk($sformatf("v%0d_bhit", i), 32'(fwd_b_hit), 32'(t.e_bhit));
            chk($sformatf("v%0d_stall", i), 32'(fwd_stall), 32'(t.e_stall));
            step();
        end

        // streaming push+pop at occupancy 1: head must advance 1,2,3,4
        drive(1, 1, 2, 1, 0, 1, 0, 0, 0);
        step();
        for (int k = 1; k <= 4; k++) begin
            if (k < 4) drive(1, 32'(k + 1), 2, 1, 0, 1, 0, 0, 0);
            else       drive(0, 0, 0, 0, 0, 1, 0, 0, 0);
            #1;
            chk("stream_occ", 32'(occupancy), 1);
            chk("stream_out_r", out_r, 32'(k));
            step();
        end
        chk("stream_drained", 32'(occupancy), 0);

        // flush at occupancy 2 with an incoming entry
        drive(1, 'hA1, 1, 1, 0, 0, 0, 0, 0); step();
        drive(1, 'hA2, 1, 1, 0, 0, 0, 0, 0); step();
        chk("fl_full", 32'(occupancy), 2);
        drive(1, 'hEE, 1, 1, 0, 0, 1, 0, 0); step();
        chk("fl_occ", 32'(occupancy), 0);
        chk("fl_ovld", 32'(out_valid), 0);
        drive(0, 0, 0, 0, 0, 1, 0, 1, 0); #1;
        chk("fl_no_hit", 32'(fwd_a_hit), 0);
        step();
        chk("fl_still_empty", 32'(out_valid), 0);

        // asynchronous reset pulse mid-cycle at occupancy 2
        drive(1, 'hB1, 6, 1, 0, 0, 0, 6, 0); step();
        drive(1, 'hB2, 6, 1, 0, 0, 0, 6, 0); step();
        drive(0, 0, 0, 0, 0, 0, 0, 6, 0);
        #2 resetn = 1'b0;
        #1;
        chk("ar_occ", 32'(occupancy), 0);
        chk("ar_ovld", 32'(out_valid), 0);
        chk("ar_out_r", out_r, 0);
        chk("ar_irdy", 32'(in_ready), 1);
        chk("ar_ahit", 32'(fwd_a_hit), 0);
        #1 resetn = 1'b1;
        step();
        chk("ar_after", 32'(occupancy), 0);

        // randomized traffic against the queue model
        q = {};
        for (int c = 0; c < 600; c++) begin
            logic eh, ebh, ela, elb;
            logic [31:0] ed, ebd;
            in_valid  = ($urandom_range(0, 3) != 0);
            in_r      = $urandom();
            in_sv     = $urandom();
            in_z      = 1'($urandom());
            in_rn     = 5'($urandom_range(0, 3));
            in_wreg   = ($urandom_range(0, 3) != 0);
            in_m2reg  = ($urandom_range(0, 3) == 0);
            in_wmem   = 1'($urandom());
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 30) == 0);
            fwd_rs    = 5'($urandom_range(0, 3));
            fwd_rt    = 5'($urandom_range(0, 3));
            #1;
            chk("rnd_occ", 32'(occupancy), 32'(q.size()));
            chk("rnd_ovld", 32'(out_valid), 32'(q.size() != 0));
            chk("rnd_irdy", 32'(in_ready), 32'(q.size() != 2));
            if (q.size() != 0) begin
                chk("rnd_out_r", out_r, q[0].r);
                chk("rnd_out_sv", out_sv, q[0].sv);
                chk("rnd_out_ctl", {26'h0, out_rn, out_z, out_wreg, out_m2reg, out_wmem},
                    {26'h0, q[0].rn, q[0].z, q[0].wreg, q[0].m2, q[0].wmem});
            end
            mlook(fwd_rs, eh, ed, ela);
            mlook(fwd_rt, ebh, ebd, elb);
            chk("rnd_ahit", 32'(fwd_a_hit), 32'(eh));
            chk("rnd_adata", fwd_a_data, ed);
            chk("rnd_bhit", 32'(fwd_b_hit), 32'(ebh));
            chk("rnd_bdata", fwd_b_data, ebd);
            chk("rnd_stall", 32'(fwd_stall), 32'(ela | elb));
            begin
                logic do_push, do_pop;
                do_push = in_valid && (q.size() != 2);
                do_pop  = out_ready && (q.size() != 0);
                if (flush) q = {};
                else begin
                    if (do_pop) void'(q.pop_front());
                    if (do_push) q.push_back('{r: in_r, z: in_z, rn: in_rn, wreg: in_wreg,
                                               m2: in_m2reg, wmem: in_wmem, sv: in_sv});
                end
            end
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
